// File: rtl/jts18_vdp_mix.sv
// Final System 18 pixel mixer: aligns colour to the vdp_sel decision, selects, blanks.
// Optional per-frame VDP pixel counter enabled by defining JTS18_MIXSTAT_EN.
module jts18_vdp_mix #(
  parameter int unsigned SEL_DLY = 2,
  parameter int unsigned CNTW    = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pxl_cen,
  input  logic            LHBL,
  input  logic            LVBL,
  input  logic [14:0]     s16_rgb,
  input  logic [8:0]      vdp_rgb,
  input  logic            vdp_en,
  input  logic            vdp_sel,
  output logic [4:0]      red,
  output logic [4:0]      green,
  output logic [4:0]      blue,
  output logic            LHBL_dly,
  output logic            LVBL_dly,
  output logic [CNTW-1:0] vdp_frame_cnt,
  output logic            frame_done
);

  typedef struct packed {
    logic [14:0] s16;
    logic [8:0]  vdp;
    logic        lhbl;
    logic        lvbl;
  } pxl_t;

  pxl_t        dly_q [SEL_DLY];
  pxl_t        sel_stage;
  logic [14:0] rgb_d, rgb_q;
  logic        lhbl_q, lvbl_q;
  logic        visible, use_vdp;

  // 3-bit VDP component widened by replicating its top bits into the LSBs
  function automatic logic [4:0] exp3(input logic [2:0] c);
    return {c, c[2:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SEL_DLY; i++) dly_q[i] <= '0;
    end else if (pxl_cen) begin
      dly_q[0] <= {s16_rgb, vdp_rgb, LHBL, LVBL};
      for (int unsigned i = 1; i < SEL_DLY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  always_comb begin
    sel_stage = dly_q[SEL_DLY-1];
    visible   = sel_stage.lhbl & sel_stage.lvbl;
    use_vdp   = vdp_sel & vdp_en;
    rgb_d     = '0;
    if (visible) begin
      rgb_d = use_vdp ? {exp3(sel_stage.vdp[8:6]), exp3(sel_stage.vdp[5:3]),
                         exp3(sel_stage.vdp[2:0])}
                      : sel_stage.s16;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q  <= '0;
      lhbl_q <= 1'b0;
      lvbl_q <= 1'b0;
    end else if (pxl_cen) begin
      rgb_q  <= rgb_d;
      lhbl_q <= sel_stage.lhbl;
      lvbl_q <= sel_stage.lvbl;
    end
  end

  assign red      = rgb_q[14:10];
  assign green    = rgb_q[9:5];
  assign blue     = rgb_q[4:0];
  assign LHBL_dly = lhbl_q;
  assign LVBL_dly = lvbl_q;

`ifdef JTS18_MIXSTAT_EN
  logic            lvbl_prev_q;
  logic            done_q;
  logic            frame_fall;
  logic [CNTW-1:0] cnt_d, cnt_q, frame_q;

  // A pixel landing on the frame edge is blanked, so clearing wins over counting
  always_comb begin
    frame_fall = lvbl_prev_q & ~lvbl_q;
    cnt_d      = cnt_q;
    if (frame_fall)
      cnt_d = '0;
    else if (pxl_cen && visible && use_vdp && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvbl_prev_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      frame_q     <= '0;
    end else begin
      lvbl_prev_q <= lvbl_q;
      done_q      <= frame_fall;
      cnt_q       <= cnt_d;
      if (frame_fall) frame_q <= cnt_q;
    end
  end

  assign vdp_frame_cnt = frame_q;
  assign frame_done    = done_q;
`else
  assign vdp_frame_cnt = '0;
  assign frame_done    = 1'b0;
`endif

endmodule
